// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared alarm channel state encoding and BCD time layout
package alarm_pkg;

  localparam int BCD_TIME_W = 24;

  // Digit-pair offsets within the HH:MM:SS BCD time word
  localparam int HH_LSB = 16;
  localparam int MM_LSB = 8;
  localparam int SS_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RINGING,
    ST_SNOOZED
  } alarm_state_e;

endpackage

// File: rtl/alarm_channel.sv
// rtl/alarm_channel.sv - one alarm channel: time compare, entering-edge trigger, ring/snooze timers
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int TIME_W     = BCD_TIME_W,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int CNT_W      = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              en_i,
  input  logic              tick_i,
  input  logic [TIME_W-1:0] cur_time_i,
  input  logic [TIME_W-1:0] alarm_time_i,
  input  logic              active_i,
  input  logic              any_ringing_i,
  input  logic              snooze_i,
  input  logic              dismiss_i,
  output logic              ringing_o,
  output logic              snoozed_o,
  output logic              timeout_o
);

  localparam int SNZ_W = $clog2(MAX_SNOOZE + 2);

  alarm_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SNZ_W-1:0] snz_q;
  logic             match_q;
  logic             timeout_q;
  logic             match;
  logic             trigger;

  assign match   = (alarm_time_i == cur_time_i);
  assign trigger = match & ~match_q;

  // match_q resets high so a time that already matches cannot fire right after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      snz_q     <= '0;
      match_q   <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      match_q   <= match;
      timeout_q <= 1'b0;
      if (!start_i || !en_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        snz_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_ARMED;
          ST_ARMED: begin
            if (trigger) begin
              state_q <= ST_RINGING;
              cnt_q   <= CNT_W'(RING_SEC);
              snz_q   <= '0;
            end
          end
          ST_RINGING: begin
            if (active_i && dismiss_i) begin
              state_q <= ST_ARMED;
              cnt_q   <= '0;
            end else if (active_i && snooze_i && (snz_q < SNZ_W'(MAX_SNOOZE))) begin
              state_q <= ST_SNOOZED;
              cnt_q   <= CNT_W'(SNOOZE_SEC);
              snz_q   <= snz_q + SNZ_W'(1);
            end else if (tick_i) begin
              if (cnt_q <= CNT_W'(1)) begin
                state_q   <= ST_ARMED;
                cnt_q     <= '0;
                timeout_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q - CNT_W'(1);
              end
            end
          end
          ST_SNOOZED: begin
            if (dismiss_i && !any_ringing_i) begin
              state_q <= ST_ARMED;
              cnt_q   <= '0;
            end else if (tick_i) begin
              if (cnt_q <= CNT_W'(1)) begin
                state_q <= ST_RINGING;
                cnt_q   <= CNT_W'(RING_SEC);
              end else begin
                cnt_q <= cnt_q - CNT_W'(1);
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign ringing_o = (state_q == ST_RINGING);
  assign snoozed_o = (state_q == ST_SNOOZED);
  assign timeout_o = timeout_q;

endmodule

// File: rtl/alarm_scheduler.sv
// rtl/alarm_scheduler.sv - multi-channel alarm controller driving the shared play request
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int N_ALARMS   = 4,
  parameter int TIME_W     = BCD_TIME_W,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int CNT_W      = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       tick_1hz,
  input  logic [TIME_W-1:0]          current_time,
  input  logic [N_ALARMS*TIME_W-1:0] alarm_time,
  input  logic [N_ALARMS-1:0]        alarm_en,
  input  logic                       snooze,
  input  logic                       dismiss,
  output logic                       play,
  output logic [N_ALARMS-1:0]        ringing,
  output logic [N_ALARMS-1:0]        snoozed,
  output logic [2:0]                 active_id,
  output logic                       active_valid,
  output logic                       ring_timeout
);

  logic [N_ALARMS-1:0] active_oh;
  logic [N_ALARMS-1:0] timeout_hit;

  // Lowest set bit of ringing: only that channel sees snooze/dismiss
  assign active_oh = ringing & (~ringing + N_ALARMS'(1));

  for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
    alarm_channel #(
      .TIME_W    (TIME_W),
      .RING_SEC  (RING_SEC),
      .SNOOZE_SEC(SNOOZE_SEC),
      .MAX_SNOOZE(MAX_SNOOZE),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .en_i         (alarm_en[i]),
      .tick_i       (tick_1hz),
      .cur_time_i   (current_time),
      .alarm_time_i (alarm_time[i*TIME_W +: TIME_W]),
      .active_i     (active_oh[i]),
      .any_ringing_i(active_valid),
      .snooze_i     (snooze),
      .dismiss_i    (dismiss),
      .ringing_o    (ringing[i]),
      .snoozed_o    (snoozed[i]),
      .timeout_o    (timeout_hit[i])
    );
  end

  always_comb begin
    active_id = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (ringing[i]) active_id = 3'(i);
    end
  end

  assign active_valid = |ringing;
  assign play         = |ringing;
  assign ring_timeout = |timeout_hit;

endmodule
